// File: rtl/somasub_pkg.sv
// somasub_pkg: types and constants shared by the add/subtract front end.
//   OP_W             operand width fed to the adder
//   DEBOUNCE_DEFAULT stable-cycle count for a real board clock
//   stage_e          operand-entry FSM states, encoding also drives the LEDs
package somasub_pkg;
  localparam int OP_W             = 4;
  localparam int DEBOUNCE_DEFAULT = 50000;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_SHOW = 2'b10
  } stage_e;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: raw active-low push button -> single-cycle press pulse.
//   clk, rst_n  clock, synchronous active-low reset
//   key_n       raw button level (active-low, bouncing, async to clk)
//   press       one-cycle pulse the cycle after the debounced level rises
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // synchronizer kept in raw polarity so reset parks it at "released"
  logic [1:0]    sync_n;
  logic          lvl_sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  assign lvl_sync = ~sync_n[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_n  <= 2'b11;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_n  <= {sync_n[0], key_n};
      level_q <= level;
      press   <= level & ~level_q;
      // any agreement restarts the count, so short glitches never accumulate
      if (lvl_sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= lvl_sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: enters two operands and the add/sub select from the
// slide switches, one ENTER press per step, for the 4-bit adder/subtractor.
//   clk, rst_n          clock, synchronous active-low reset
//   sw, sw_op           operand switches / 0=add 1=sub (async)
//   key_enter_n         ENTER button, raw active-low
//   key_clr_n           CLEAR button, raw active-low
//   n1, n2, tr0         registered adder operands and subtract select
//   valid               n1/n2/tr0 form a complete confirmed operation
//   stage               current FSM state for the LEDs
module operand_sequencer
  import somasub_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] sw,
  input  logic            sw_op,
  input  logic            key_enter_n,
  input  logic            key_clr_n,
  output logic [OP_W-1:0] n1,
  output logic [OP_W-1:0] n2,
  output logic            tr0,
  output logic            valid,
  output logic [1:0]      stage
);
  localparam int NBTN = 2;

  logic [NBTN-1:0] keys_n;
  logic [NBTN-1:0] press;
  logic            ent;
  logic            clr;

  // index 0 = ENTER, 1 = CLEAR
  assign keys_n = {key_clr_n, key_enter_n};
  assign ent    = press[0];
  assign clr    = press[1];

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (keys_n[i]),
      .press (press[i])
    );
  end

  // switches carry the op bit on top so one synchronizer handles both
  logic [OP_W:0] sw_s1;
  logic [OP_W:0] sw_s2;

  stage_e          state, state_d;
  logic [OP_W-1:0] n1_d, n2_d;
  logic            tr0_d, valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      state <= S_A;
      n1    <= '0;
      n2    <= '0;
      tr0   <= 1'b0;
      valid <= 1'b0;
    end else begin
      sw_s1 <= {sw_op, sw};
      sw_s2 <= sw_s1;
      state <= state_d;
      n1    <= n1_d;
      n2    <= n2_d;
      tr0   <= tr0_d;
      valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    n1_d    = n1;
    n2_d    = n2;
    tr0_d   = tr0;
    valid_d = valid;
    if (clr) begin
      // clear has priority; a coincident enter is dropped
      state_d = S_A;
      n1_d    = '0;
      n2_d    = '0;
      tr0_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state)
        S_A: if (ent) begin
          n1_d    = sw_s2[OP_W-1:0];
          state_d = S_B;
        end
        S_B: if (ent) begin
          n2_d    = sw_s2[OP_W-1:0];
          tr0_d   = sw_s2[OP_W];
          valid_d = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: if (ent) begin
          valid_d = 1'b0;
          state_d = S_A;
        end
        default: begin
          // unreachable encoding: recover as a clear
          state_d = S_A;
          n1_d    = '0;
          n2_d    = '0;
          tr0_d   = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign stage = state;
endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       sw_op;
  logic       key_enter_n;
  logic       key_clr_n;
  logic [3:0] n1, n2;
  logic       tr0, valid;
  logic [1:0] stage;

  int total = 0;
  int bad   = 0;

  operand_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .sw_op       (sw_op),
    .key_enter_n (key_enter_n),
    .key_clr_n   (key_clr_n),
    .n1          (n1),
    .n2          (n2),
    .tr0         (tr0),
    .valid       (valid),
    .stage       (stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // hold long enough for a press, then long enough for the release to settle
  task automatic press_enter();
    key_enter_n = 1'b0;
    cyc(DB + 6);
    key_enter_n = 1'b1;
    cyc(DB + 8);
  endtask

  initial begin
    rst_n = 1'b0; sw = 4'h0; sw_op = 1'b0;
    key_enter_n = 1'b1; key_clr_n = 1'b1;
    cyc(2);
    chk("rst_n1", n1, 0);
    chk("rst_n2", n2, 0);
    chk("rst_tr0", tr0, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stage", stage, 0);
    rst_n = 1'b1;

    // first operand, exact latency: key first sampled low at edge k,
    // outputs change at edge k+DB+3
    sw = 4'h5; sw_op = 1'b0;
    cyc(3);
    key_enter_n = 1'b0;
    cyc(DB + 3);
    chk("lat_a_early_stage", stage, 0);
    chk("lat_a_early_n1", n1, 0);
    cyc(1);
    chk("lat_a_stage", stage, 1);
    chk("lat_a_n1", n1, 5);
    cyc(3);
    key_enter_n = 1'b1;
    cyc(DB + 8);

    // switch noise without ENTER changes nothing
    for (int i = 0; i < 20; i++) begin
      sw = ~sw; sw_op = ~sw_op;
      cyc(1);
    end
    chk("tog_n1", n1, 5);
    chk("tog_n2", n2, 0);
    chk("tog_stage", stage, 1);
    chk("tog_valid", valid, 0);

    // second operand with subtract, same latency
    sw = 4'h3; sw_op = 1'b1;
    cyc(3);
    key_enter_n = 1'b0;
    cyc(DB + 3);
    chk("lat_b_early_valid", valid, 0);
    chk("lat_b_early_n2", n2, 0);
    cyc(1);
    chk("lat_b_n1", n1, 5);
    chk("lat_b_n2", n2, 3);
    chk("lat_b_tr0", tr0, 1);
    chk("lat_b_valid", valid, 1);
    chk("lat_b_stage", stage, 2);
    cyc(3);
    key_enter_n = 1'b1;
    cyc(DB + 8);

    // ENTER in S_SHOW: back to S_A, operands held
    press_enter();
    chk("show_stage", stage, 0);
    chk("show_valid", valid, 0);
    chk("show_n1", n1, 5);
    chk("show_n2", n2, 3);
    chk("show_tr0", tr0, 1);

    // bouncing ENTER: low 2, high 1, then steady low -> one advance only
    sw = 4'h7; sw_op = 1'b0;
    cyc(3);
    key_enter_n = 1'b0; cyc(2);
    key_enter_n = 1'b1; cyc(1);
    key_enter_n = 1'b0; cyc(20);
    chk("bounce_stage", stage, 1);
    chk("bounce_n1", n1, 7);
    key_enter_n = 1'b1;
    cyc(DB + 8);

    sw = 4'h2; sw_op = 1'b0;
    cyc(3);
    press_enter();
    chk("b2_n2", n2, 2);
    chk("b2_tr0", tr0, 0);
    chk("b2_valid", valid, 1);
    chk("b2_stage", stage, 2);

    // ENTER and CLEAR pulses in the same cycle: clear wins
    key_enter_n = 1'b0; key_clr_n = 1'b0;
    cyc(DB + 6);
    key_enter_n = 1'b1; key_clr_n = 1'b1;
    cyc(DB + 8);
    chk("both_n1", n1, 0);
    chk("both_n2", n2, 0);
    chk("both_tr0", tr0, 0);
    chk("both_valid", valid, 0);
    chk("both_stage", stage, 0);

    // reset in the middle of a debounce count
    sw = 4'h9;
    cyc(3);
    press_enter();
    chk("pre_rst_n1", n1, 9);
    chk("pre_rst_stage", stage, 1);
    key_enter_n = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    cyc(2);
    chk("mid_rst_n1", n1, 0);
    chk("mid_rst_stage", stage, 0);
    key_enter_n = 1'b1;
    rst_n = 1'b1;
    cyc(20);
    chk("post_rst_n1", n1, 0);
    chk("post_rst_stage", stage, 0);
    chk("post_rst_valid", valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
